// File: rtl/pll_lock_detect.sv
// PLL lock detector, reference-clock domain.
// Frequency lock is declared once the DCO control word stays steady for long enough.
// Phase lock is then declared once the phase error also stays small.
// Each lock level is dropped only after several consecutive bad samples (hysteresis).
module pll_lock_detect #(
    parameter int W              = 16,
    parameter int FREQ_LOCK_CNT  = 16,
    parameter int PHASE_LOCK_CNT = 32,
    parameter int PHASE_TOL      = 4,
    parameter int UNLOCK_CNT     = 4
) (
    input  logic         clk_ref,
    input  logic         n_rst,
    input  logic         enable,
    input  logic         sample_valid,
    input  logic [W-1:0] pherr,
    input  logic [W-1:0] ctrl_word,
    input  logic [1:0]   freq_lock_range,
    output logic         freq_locked,
    output logic         phase_locked,
    output logic [1:0]   lock_state,
    output logic         lost_lock
);

    // state | meaning
    // IDLE  | detector disabled, nothing qualified
    // ACQ   | waiting for a steady control word
    // FLOCK | frequency locked, waiting for small phase error
    // PLOCK | frequency and phase locked
    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, FLOCK = 2'd2, PLOCK = 2'd3} state_t;

    localparam int FCW = $clog2(FREQ_LOCK_CNT + 1);
    localparam int PCW = $clog2(PHASE_LOCK_CNT + 1);
    localparam int BCW = $clog2(UNLOCK_CNT + 1);
    localparam logic [FCW-1:0] F_THR  = FCW'(FREQ_LOCK_CNT);
    localparam logic [PCW-1:0] P_THR  = PCW'(PHASE_LOCK_CNT);
    localparam logic [BCW-1:0] B_THR  = BCW'(UNLOCK_CNT);
    localparam logic [W:0]     PH_TOL = (W+1)'(PHASE_TOL);

    state_t         state, state_nxt;
    logic [FCW-1:0] freq_cnt, f_nxt, f_inc;
    logic [PCW-1:0] phase_cnt, p_nxt, p_inc, p_cand;
    logic [BCW-1:0] bad_cnt, b_nxt, b_inc, b_cand;
    logic           prev_valid, pv_nxt;
    logic [W-1:0]   ctrl_prev, cp_nxt;
    logic           lost_nxt;

    logic [W:0] ctrl_ext, prev_ext, delta, ph_ext, abs_ph, tol;
    logic       freq_ok, phase_ok;

    // Both magnitudes are kept one bit wider so neither can wrap:
    // a full-scale control-word jump and the most negative phase error both stay large.
    assign ctrl_ext = {1'b0, ctrl_word};
    assign prev_ext = {1'b0, ctrl_prev};
    assign delta    = (ctrl_ext >= prev_ext) ? (ctrl_ext - prev_ext) : (prev_ext - ctrl_ext);
    assign ph_ext   = {pherr[W-1], pherr};
    assign abs_ph   = ph_ext[W] ? (~ph_ext + 1'b1) : ph_ext;
    assign tol      = (W+1)'(2) << freq_lock_range;
    assign freq_ok  = prev_valid && (delta <= tol);
    assign phase_ok = freq_ok && (abs_ph <= PH_TOL);

    assign f_inc = (freq_cnt == F_THR)  ? freq_cnt  : freq_cnt + 1'b1;
    assign p_inc = (phase_cnt == P_THR) ? phase_cnt : phase_cnt + 1'b1;
    assign b_inc = (bad_cnt == B_THR)   ? bad_cnt   : bad_cnt + 1'b1;

    // Next-state and counter update; every state change clears all three counters.
    always_comb begin
        state_nxt = state;
        f_nxt     = freq_cnt;
        p_nxt     = phase_cnt;
        b_nxt     = bad_cnt;
        pv_nxt    = prev_valid;
        cp_nxt    = ctrl_prev;
        lost_nxt  = 1'b0;
        p_cand    = '0;
        b_cand    = '0;
        if (!enable) begin
            state_nxt = IDLE;
            f_nxt     = '0;
            p_nxt     = '0;
            b_nxt     = '0;
            pv_nxt    = 1'b0;
        end else if (state == IDLE) begin
            state_nxt = ACQ;
        end else if (sample_valid) begin
            cp_nxt = ctrl_word;
            pv_nxt = 1'b1;
            // The priming sample only establishes a reference control word.
            if (prev_valid) begin
                unique case (state)
                    ACQ: begin
                        if (!freq_ok) begin
                            f_nxt = '0;
                        end else if (f_inc == F_THR) begin
                            state_nxt = FLOCK;
                            f_nxt     = '0;
                        end else begin
                            f_nxt = f_inc;
                        end
                    end
                    FLOCK: begin
                        p_cand = phase_ok ? p_inc : '0;
                        b_cand = freq_ok ? '0 : b_inc;
                        if (b_cand == B_THR) begin
                            state_nxt = ACQ;
                            lost_nxt  = 1'b1;
                            p_nxt     = '0;
                            b_nxt     = '0;
                        end else if (p_cand == P_THR) begin
                            state_nxt = PLOCK;
                            p_nxt     = '0;
                            b_nxt     = '0;
                        end else begin
                            p_nxt = p_cand;
                            b_nxt = b_cand;
                        end
                    end
                    PLOCK: begin
                        b_cand = phase_ok ? '0 : b_inc;
                        if (b_cand == B_THR) begin
                            state_nxt = freq_ok ? FLOCK : ACQ;
                            lost_nxt  = 1'b1;
                            b_nxt     = '0;
                        end else begin
                            b_nxt = b_cand;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_ref or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            freq_cnt     <= '0;
            phase_cnt    <= '0;
            bad_cnt      <= '0;
            prev_valid   <= 1'b0;
            ctrl_prev    <= '0;
            freq_locked  <= 1'b0;
            phase_locked <= 1'b0;
            lost_lock    <= 1'b0;
        end else begin
            state        <= state_nxt;
            freq_cnt     <= f_nxt;
            phase_cnt    <= p_nxt;
            bad_cnt      <= b_nxt;
            prev_valid   <= pv_nxt;
            ctrl_prev    <= cp_nxt;
            freq_locked  <= (state_nxt == FLOCK) || (state_nxt == PLOCK);
            phase_locked <= (state_nxt == PLOCK);
            lost_lock    <= lost_nxt;
        end
    end

    assign lock_state = state;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect; expected status per cycle is queued by the stimulus and
// checked by an independent monitor.
module tb_pll_lock_detect;

    localparam logic [1:0] S_IDLE = 2'd0, S_ACQ = 2'd1, S_FLOCK = 2'd2, S_PLOCK = 2'd3;

    logic        clk_ref = 1'b0;
    logic        n_rst;
    logic        enable;
    logic        sample_valid;
    logic [15:0] pherr;
    logic [15:0] ctrl_word;
    logic [1:0]  freq_lock_range;
    logic        freq_locked;
    logic        phase_locked;
    logic [1:0]  lock_state;
    logic        lost_lock;

    int          total = 0;
    int          bad   = 0;
    logic [2:0]  exp_q[$];
    logic        chk = 1'b0;
    string       tag = "init";

    pll_lock_detect dut (
        .clk_ref         (clk_ref),
        .n_rst           (n_rst),
        .enable          (enable),
        .sample_valid    (sample_valid),
        .pherr           (pherr),
        .ctrl_word       (ctrl_word),
        .freq_lock_range (freq_lock_range),
        .freq_locked     (freq_locked),
        .phase_locked    (phase_locked),
        .lock_state      (lock_state),
        .lost_lock       (lost_lock)
    );

    always #5 clk_ref = ~clk_ref;

    // Compare {lock_state, freq_locked, phase_locked, lost_lock} against the required value.
    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got st=%0d fl=%b pl=%b lost=%b, want st=%0d fl=%b pl=%b lost=%b (t=%0t)",
                     name, act[4:3], act[2], act[1], act[0], req[4:3], req[2], req[1], req[0], $time);
        end
    endtask

    // Apply one cycle of inputs at a falling edge and queue the status expected after the next rising edge.
    task automatic drive(input logic v, input logic en, input logic [15:0] ph, input logic [15:0] cw,
                         input logic [1:0] rng, input logic [1:0] es, input logic el);
        sample_valid    = v;
        enable          = en;
        pherr           = ph;
        ctrl_word       = cw;
        freq_lock_range = rng;
        exp_q.push_back({es, el});
        chk = 1'b1;
        @(negedge clk_ref);
        sample_valid = 1'b0;
        chk = 1'b0;
    endtask

    // Monitor: after each rising edge the stimulus marked, pop the expectation and compare.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk_ref);
            if (chk) begin
                #1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s: got no queued expectation, want one", tag);
                end else begin
                    e = exp_q.pop_front();
                    check(tag, {lock_state, freq_locked, phase_locked, lost_lock},
                          {e[2:1], e[2], (e[2:1] == S_PLOCK), e[0]});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] cw;
        logic [15:0] ph;
        n_rst = 1'b0; enable = 1'b0; sample_valid = 1'b0;
        pherr = '0; ctrl_word = '0; freq_lock_range = 2'd1;
        @(negedge clk_ref);

        tag = "reset";
        drive(0, 0, 16'h0, 16'h0, 2'd1, S_IDLE, 0);
        drive(1, 0, 16'h0, 16'h0, 2'd1, S_IDLE, 0);
        n_rst = 1'b1;

        tag = "idle_disabled";
        for (int i = 0; i < 50; i++) drive(1, 0, 16'(i), 16'h0800, 2'd1, S_IDLE, 0);

        tag = "enable_to_acq";
        drive(0, 1, 16'h0, 16'h0800, 2'd1, S_ACQ, 0);

        // 1 priming sample + 16 steady ones reach frequency lock.
        tag = "freq_acq";
        for (int i = 0; i < 17; i++)
            drive(1, 1, 16'd100, 16'h0800, 2'd1, (i == 16) ? S_FLOCK : S_ACQ, 0);

        // +/-4 sits on the tolerance; +5 at sample 31 and 0x8000 later each restart the phase count.
        tag = "phase_acq";
        for (int i = 0; i < 95; i++) begin
            ph = (i == 30) ? 16'h0005 : (i == 62) ? 16'h8000 : (i % 2 == 1) ? 16'hFFFC : 16'h0004;
            drive(1, 1, ph, 16'h0800, 2'd1, (i == 94) ? S_PLOCK : S_FLOCK, 0);
        end

        tag = "hyst_hold";
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) drive(1, 1, 16'd20, 16'h0800, 2'd1, S_PLOCK, 0);
            drive(1, 1, 16'd0, 16'h0800, 2'd1, S_PLOCK, 0);
        end
        tag = "hyst_drop";
        for (int i = 0; i < 4; i++)
            drive(1, 1, 16'd20, 16'h0800, 2'd1, (i == 3) ? S_FLOCK : S_PLOCK, (i == 3));
        tag = "hyst_pulse_end";
        drive(0, 1, 16'd0, 16'h0800, 2'd1, S_FLOCK, 0);

        tag = "relock_1";
        for (int i = 0; i < 32; i++)
            drive(1, 1, 16'd0, 16'h0800, 2'd1, (i == 31) ? S_PLOCK : S_FLOCK, 0);

        tag = "step9_range3";
        cw = 16'h0800;
        for (int i = 0; i < 6; i++) begin
            cw = cw + 16'd9;
            drive(1, 1, 16'd0, cw, 2'd3, S_PLOCK, 0);
        end
        tag = "step9_range2";
        for (int i = 0; i < 4; i++) begin
            cw = cw + 16'd9;
            drive(1, 1, 16'd0, cw, 2'd2, (i == 3) ? S_ACQ : S_PLOCK, (i == 3));
        end
        tag = "freq_loss_pulse_end";
        drive(0, 1, 16'd0, cw, 2'd2, S_ACQ, 0);

        // 0xFFFF -> 0x0000 is a full-scale jump; it must not complete the count of 16.
        tag = "wrap_delta";
        for (int i = 0; i < 16; i++) drive(1, 1, 16'd0, 16'hFFFF, 2'd3, S_ACQ, 0);
        drive(1, 1, 16'd0, 16'h0000, 2'd3, S_ACQ, 0);
        tag = "reacq_after_wrap";
        for (int i = 0; i < 16; i++)
            drive(1, 1, 16'd0, 16'h0000, 2'd3, (i == 15) ? S_FLOCK : S_ACQ, 0);
        tag = "relock_2";
        for (int i = 0; i < 32; i++)
            drive(1, 1, 16'd0, 16'h0000, 2'd3, (i == 31) ? S_PLOCK : S_FLOCK, 0);

        tag = "enable_drop";
        drive(1, 0, 16'd20, 16'h0000, 2'd3, S_IDLE, 0);
        tag = "reenable";
        drive(0, 1, 16'd0, 16'h0000, 2'd3, S_ACQ, 0);
        tag = "reprime_freq";
        for (int i = 0; i < 17; i++)
            drive(1, 1, 16'd0, 16'h0000, 2'd3, (i == 16) ? S_FLOCK : S_ACQ, 0);
        tag = "reprime_phase";
        for (int i = 0; i < 32; i++)
            drive(1, 1, 16'd0, 16'h0000, 2'd3, (i == 31) ? S_PLOCK : S_FLOCK, 0);

        // Asynchronous reset in the middle of a cycle while phase locked.
        #2 n_rst = 1'b0;
        #1 check("async_reset", {lock_state, freq_locked, phase_locked, lost_lock}, 5'b0);
        @(negedge clk_ref);
        n_rst = 1'b1;
        tag = "after_reset";
        drive(0, 0, 16'd0, 16'h0000, 2'd3, S_IDLE, 0);

        repeat (2) @(negedge clk_ref);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_detect.md
Name: pll_lock_detect

Overview:
Digital lock detector for the PLL, clocked in the reference-clock domain. It consumes one sample per reference cycle from the loop: the signed phase error from the phase detector, and the DCO control word from the PI loop filter. It qualifies frequency lock from control-word stability and phase lock from phase-error magnitude, with hysteresis. It produces the freq_locked and phase_locked status bits that the PLL top level exports.

Parameters:
W, 16, width of pherr and ctrl_word
FREQ_LOCK_CNT, 16, consecutive freq-good samples required to declare frequency lock
PHASE_LOCK_CNT, 32, consecutive phase-good samples (while freq-good) required to declare phase lock
PHASE_TOL, 4, phase-good when |pherr| <= PHASE_TOL (DCO ticks)
UNLOCK_CNT, 4, consecutive bad samples that drop a lock level

Ports:
clk_ref  input  1  reference clock; single clock domain
n_rst  input  1  reset, asynchronous, active-low
enable  input  1  detector enable; low forces IDLE
sample_valid  input  1  one-cycle strobe; pherr/ctrl_word valid this cycle
pherr  input  W  signed phase error, two's complement
ctrl_word  input  W  unsigned DCO control word from loop filter
freq_lock_range  input  2  freq tolerance select: 0->2, 1->4, 2->8, 3->16 LSB
freq_locked  output  1  frequency lock status
phase_locked  output  1  phase lock status
lock_state  output  2  0 IDLE, 1 ACQ, 2 FLOCK, 3 PLOCK
lost_lock  output  1  one-cycle pulse on any lock-level drop

Behaviour:
- Reset (n_rst=0, async): state=IDLE; all counters=0; prev_valid=0; ctrl_prev=0. Outputs freq_locked=0, phase_locked=0, lock_state=0, lost_lock=0.
- All outputs are registered. freq_locked=1 iff state is FLOCK or PLOCK. phase_locked=1 iff state is PLOCK. lock_state equals the state encoding.
- A sample is processed only when sample_valid=1 and enable=1. sample_valid is ignored otherwise.
- First processed sample after leaving IDLE only loads ctrl_prev and sets prev_valid. It is neither good nor bad.
- Every processed sample loads ctrl_prev <= ctrl_word.
- delta = |ctrl_word - ctrl_prev|, computed in W+1 bits with no wrap.
- freq_ok = prev_valid && delta <= tol(freq_lock_range). tol is sampled on the same cycle as the sample.
- abs_ph = |pherr| in W+1 bits; the most negative value gives 2^(W-1), not a wrap.
- phase_ok = freq_ok && abs_ph <= PHASE_TOL.
- IDLE: when enable=1 go to ACQ next cycle.
- ACQ:
  - freq_cnt increments on freq_ok and clears to 0 on !freq_ok.
  - When the increment reaches FREQ_LOCK_CNT, go to FLOCK on the next edge and clear all counters.
- FLOCK:
  - phase_cnt increments on phase_ok and clears on !phase_ok.
  - bad_cnt increments on !freq_ok and clears on freq_ok.
  - phase_cnt reaching PHASE_LOCK_CNT -> PLOCK.
  - bad_cnt reaching UNLOCK_CNT -> ACQ with lost_lock pulse.
  - bad_cnt takes priority if both reach threshold on the same sample.
- PLOCK:
  - bad_cnt increments on !phase_ok and clears on phase_ok.
  - When it reaches UNLOCK_CNT: go to ACQ if the final sample had !freq_ok, else go to FLOCK.
  - Either drop raises lost_lock for one cycle.
- Latency: status changes on the clk_ref edge after the qualifying sample_valid cycle.
- Every state transition clears freq_cnt, phase_cnt and bad_cnt. prev_valid persists except in IDLE.
- Counters saturate at their threshold and never wrap. Counter width is clog2(threshold+1).
- enable deasserted in any state:
  - IDLE next cycle; outputs 0; counters and prev_valid cleared.
  - No lost_lock pulse.
  - A sample arriving in that same cycle is discarded.
- Back-to-back sample_valid on consecutive cycles is legal; each sample is processed.
- Gaps between samples do not reset counters.

Test Plan:
- Reset/idle: n_rst low mid-PLOCK -> freq_locked, phase_locked, lock_state, lost_lock all 0 immediately (async). enable=0 with 50 samples -> state stays IDLE.
- Frequency acquisition: range=1, constant ctrl_word=0x0800 with pherr=100, 17 samples -> freq_locked=1 one cycle after the 17th sample (1 priming + 16 good); phase_locked=0.
- Phase acquisition plus tolerance edges:
  - Continue with pherr alternating +4/-4 for 32 samples -> PLOCK, phase_locked=1.
  - pherr=+5 at sample 31 -> phase_cnt clears, lock slips by 31 samples.
  - pherr=0x8000 -> treated as |32768|, not locked.
- Hysteresis:
  - In PLOCK, 3 samples with pherr=20 then pherr=0 -> stays PLOCK.
  - 4 consecutive samples with pherr=20 -> FLOCK, lost_lock single-cycle pulse, freq_locked stays 1.
- Frequency loss:
  - In PLOCK, ctrl_word steps by +9 per sample with range=2 -> ACQ after 4 samples, lost_lock pulse, both status bits 0.
  - Same steps with range=3 -> no frequency loss.
  - ctrl_word 0xFFFF->0x0000 -> delta=65535, not freq_ok.
- Enable drop: deassert enable in PLOCK coincident with sample_valid -> IDLE next cycle, lost_lock=0. Re-enable -> first sample is priming only, and lock requires a full 16+32 sequence again.
